// File: rtl/jtag_debug_sys_dbg_ocimem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_debug_sys_dbg_ocimem_if : debug-command and CPU word-port bundle    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface jtag_debug_sys_dbg_ocimem_if #(
    parameter int ADDR_W = 8
);
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_no_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [31:0]       cpu_writedata;
    logic [31:0]       cpu_readdata;
    logic              cpu_readdatavalid;
    logic              cpu_waitrequest;
    logic [31:0]       MonDReg;
    logic              monitor_ready;
    logic              monitor_error;

    modport master (
        output jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        output cpu_address, cpu_read, cpu_write, cpu_writedata,
        input  cpu_readdata, cpu_readdatavalid, cpu_waitrequest,
        input  MonDReg, monitor_ready, monitor_error
    );

    modport slave (
        input  jdo, take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b,
        input  cpu_address, cpu_read, cpu_write, cpu_writedata,
        output cpu_readdata, cpu_readdatavalid, cpu_waitrequest,
        output MonDReg, monitor_ready, monitor_error
    );
endinterface
`default_nettype wire

// File: rtl/jtag_debug_sys_dbg_ocimem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_debug_sys_dbg_ocimem : debug RAM engine with arbitrated CPU port    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module jtag_debug_sys_dbg_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    jtag_debug_sys_dbg_ocimem_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        RD_CAP  = 2'd2,
        WR      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cpu_rd_pend_q, cpu_rd_pend_d;
    logic              cpu_wr_pend_q, cpu_wr_pend_d;
    logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
    logic [31:0]       cpu_wdata_q, cpu_wdata_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;

    logic [31:0]       mem_q [2**ADDR_W];
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;

    logic              str_a, str_b, str_n, any_strobe, multi_strobe;
    logic              cpu_req, cpu_accept;
    logic [ADDR_W-1:0] addr_one;
    logic              unused_jdo;

    assign str_a        = bus.take_action_ocimem_a;
    assign str_b        = bus.take_action_ocimem_b;
    assign str_n        = bus.take_no_action_ocimem_a;
    assign any_strobe   = str_a | str_b | str_n;
    assign multi_strobe = (str_a & str_b) | (str_a & str_n) | (str_b & str_n);
    assign addr_one     = {{(ADDR_W-1){1'b0}}, 1'b1};
    assign unused_jdo   = ^{bus.jdo[37:36], bus.jdo[2:0]};

    // Debug always wins: the CPU only gets the RAM in an idle cycle without a strobe.
    assign cpu_req    = bus.cpu_read | bus.cpu_write;
    assign cpu_accept = cpu_req & (state_q == IDLE) & ~any_strobe;

    always_comb begin
        state_d   = state_q;
        mon_a_d   = mon_a_q;
        mon_d_d   = mon_d_q;
        ready_d   = ready_q;
        error_d   = error_q;
        wdata_d   = wdata_q;
        ram_we    = 1'b0;
        ram_waddr = mon_a_q;
        ram_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (str_a) begin
                    mon_a_d = bus.jdo[17 +: ADDR_W];
                    if (bus.jdo[35]) error_d = 1'b0;
                    if (bus.jdo[34]) begin
                        state_d = RD_ADDR;
                        ready_d = 1'b0;
                    end
                end else if (str_b) begin
                    wdata_d = bus.jdo[34:3];
                    state_d = WR;
                    ready_d = 1'b0;
                end else if (str_n) begin
                    state_d = RD_ADDR;
                    ready_d = 1'b0;
                end
                if (multi_strobe) error_d = 1'b1;
            end
            RD_ADDR: begin
                mon_d_d = mem_q[mon_a_q];
                state_d = RD_CAP;
            end
            RD_CAP: begin
                state_d = IDLE;
                ready_d = 1'b1;
                mon_a_d = mon_a_q + addr_one;
            end
            WR: begin
                ram_we  = 1'b1;
                state_d = IDLE;
                ready_d = 1'b1;
                mon_a_d = mon_a_q + addr_one;
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && any_strobe) error_d = 1'b1;

        // A pending CPU write never overlaps WR: it was accepted in an idle, strobe-free cycle.
        if (cpu_wr_pend_q) begin
            ram_we    = 1'b1;
            ram_waddr = cpu_addr_q;
            ram_wdata = cpu_wdata_q;
        end
    end

    always_comb begin
        cpu_wr_pend_d = cpu_accept & bus.cpu_write;
        cpu_rd_pend_d = cpu_accept & bus.cpu_read & ~bus.cpu_write;
        cpu_addr_d    = cpu_accept ? bus.cpu_address   : cpu_addr_q;
        cpu_wdata_d   = cpu_accept ? bus.cpu_writedata : cpu_wdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_rvalid_d  = 1'b0;
        if (cpu_rd_pend_q) begin
            cpu_rdata_d  = mem_q[cpu_addr_q];
            cpu_rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mon_a_q       <= '0;
            mon_d_q       <= '0;
            ready_q       <= 1'b1;
            error_q       <= 1'b0;
            wdata_q       <= '0;
            cpu_rd_pend_q <= 1'b0;
            cpu_wr_pend_q <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_wdata_q   <= '0;
            cpu_rdata_q   <= '0;
            cpu_rvalid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            mon_a_q       <= mon_a_d;
            mon_d_q       <= mon_d_d;
            ready_q       <= ready_d;
            error_q       <= error_d;
            wdata_q       <= wdata_d;
            cpu_rd_pend_q <= cpu_rd_pend_d;
            cpu_wr_pend_q <= cpu_wr_pend_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_wdata_q   <= cpu_wdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_rvalid_q  <= cpu_rvalid_d;
        end
    end

    // Contents survive reset; write enables derive from reset flops, so aborted writes drop.
    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    end

    assign bus.MonDReg           = mon_d_q;
    assign bus.monitor_ready     = ready_q;
    assign bus.monitor_error     = error_q;
    assign bus.cpu_readdata      = cpu_rdata_q;
    assign bus.cpu_readdatavalid = cpu_rvalid_q;
    assign bus.cpu_waitrequest   = cpu_req & ~cpu_accept;

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_sys_dbg_ocimem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jtag_debug_sys_dbg_ocimem : scoreboard bench for the debug RAM engine |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_jtag_debug_sys_dbg_ocimem;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    jtag_debug_sys_dbg_ocimem_if #(.ADDR_W(ADDR_W)) bus ();
    jtag_debug_sys_dbg_ocimem #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [256];
    logic [7:0]  model_addr = 8'h00;
    logic [31:0] model_mond = 32'h0;
    logic [31:0] dbg_q [$];
    logic [31:0] cpu_q [$];
    logic        prev_ready = 1'b1;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: one entry per ready-lowering debug op, one per accepted CPU read.
    always @(negedge clk) begin
        if (reset) begin
            prev_ready = 1'b1;
        end else begin
            if (bus.monitor_ready && !prev_ready) begin
                if (dbg_q.size() == 0) check_value("dbg_unexpected_done", 32'd1, 32'd0);
                else check_value("mondreg_sb", bus.MonDReg, dbg_q.pop_front());
            end
            prev_ready = bus.monitor_ready;
            if (bus.cpu_readdatavalid) begin
                if (cpu_q.size() == 0) check_value("cpu_unexpected_rvalid", 32'd1, 32'd0);
                else check_value("cpu_rdata_sb", bus.cpu_readdata, cpu_q.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int kind, input logic [37:0] j);
        bus.jdo = j;
        bus.take_action_ocimem_a    = (kind == 0);
        bus.take_action_ocimem_b    = (kind == 1);
        bus.take_no_action_ocimem_a = (kind == 2);
        next_cycle();
        bus.take_action_ocimem_a    = 1'b0;
        bus.take_action_ocimem_b    = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.jdo = '0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.monitor_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_value("idle_timeout", 32'd0, 32'd1);
        next_cycle();
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic clr, input logic rd);
        logic [37:0] j = '0;
        j[35] = clr;
        j[34] = rd;
        j[24:17] = addr;
        return j;
    endfunction

    task automatic dbg_a(input logic [7:0] addr, input logic clr, input logic rd);
        if (rd) begin
            model_mond = model_mem[addr];
            dbg_q.push_back(model_mond);
            model_addr = addr + 8'd1;
        end else begin
            model_addr = addr;
        end
        strobe(0, jdo_a(addr, clr, rd));
        wait_idle();
    endtask

    task automatic dbg_b(input logic [31:0] data);
        logic [37:0] j = '0;
        j[34:3] = data;
        model_mem[model_addr] = data;
        model_addr = model_addr + 8'd1;
        dbg_q.push_back(model_mond);
        strobe(1, j);
        wait_idle();
    endtask

    task automatic dbg_n();
        model_mond = model_mem[model_addr];
        dbg_q.push_back(model_mond);
        model_addr = model_addr + 8'd1;
        strobe(2, '0);
        wait_idle();
    endtask

    task automatic cpu_do(input logic rd, input logic wr, input logic [7:0] addr, input logic [31:0] data);
        bit done = 1'b0;
        bus.cpu_read = rd;
        bus.cpu_write = wr;
        bus.cpu_address = addr;
        bus.cpu_writedata = data;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.cpu_waitrequest) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_value("cpu_accept_timeout", 32'd0, 32'd1);
        if (wr) model_mem[addr] = data;
        else if (rd) cpu_q.push_back(model_mem[addr]);
        next_cycle();
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic check_mona(input string tag, input logic [7:0] exp);
        check_value(tag, {24'h0, dut.mon_a_q}, {24'h0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.jdo = '0;
        bus.take_action_ocimem_a = 1'b0;
        bus.take_action_ocimem_b = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_read = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_writedata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_mondreg", bus.MonDReg, 32'h0);
        check_value("rst_ready", {31'h0, bus.monitor_ready}, 32'd1);
        check_value("rst_error", {31'h0, bus.monitor_error}, 32'd0);
        check_value("rst_cpu_rdata", bus.cpu_readdata, 32'h0);
        check_value("rst_cpu_rvalid", {31'h0, bus.cpu_readdatavalid}, 32'd0);
        check_value("rst_cpu_wait", {31'h0, bus.cpu_waitrequest}, 32'd0);
        check_mona("rst_mona", 8'h00);
        reset = 1'b0;
        next_cycle();

        // Address load only: ready must not dip and no read is queued.
        model_addr = 8'h10;
        strobe(0, jdo_a(8'h10, 1'b0, 1'b0));
        @(negedge clk);
        check_value("aload_ready", {31'h0, bus.monitor_ready}, 32'd1);
        check_mona("aload_mona", 8'h10);
        next_cycle();

        // Write then timed read-back.
        dbg_b(32'hDEADBEEF);
        check_mona("wr_mona_inc", 8'h11);
        model_mond = model_mem[8'h10];
        dbg_q.push_back(model_mond);
        model_addr = 8'h11;
        strobe(0, jdo_a(8'h10, 1'b0, 1'b1));
        @(negedge clk);
        check_value("rd_ready_n1", {31'h0, bus.monitor_ready}, 32'd0);
        @(negedge clk);
        check_value("rd_ready_n2", {31'h0, bus.monitor_ready}, 32'd0);
        @(negedge clk);
        check_value("rd_ready_n3", {31'h0, bus.monitor_ready}, 32'd1);
        check_value("rd_mondreg_n3", bus.MonDReg, 32'hDEADBEEF);
        check_mona("rd_mona_inc", 8'h11);
        next_cycle();

        // Wrap at the top of the address space.
        dbg_a(8'h00, 1'b0, 1'b0);
        dbg_b(32'h01234567);
        dbg_a(8'hFF, 1'b0, 1'b0);
        dbg_b(32'hCAFEF00D);
        check_mona("wrap_after_wr", 8'h00);
        dbg_n();
        check_mona("wrap_after_rd", 8'h01);
        check_value("wrap_no_error", {31'h0, bus.monitor_error}, 32'd0);
        dbg_a(8'hFF, 1'b0, 1'b1);

        // Strobe while busy: ignored, sticky error, cleared by jdo[35].
        model_mond = model_mem[8'h10];
        dbg_q.push_back(model_mond);
        model_addr = 8'h11;
        strobe(0, jdo_a(8'h10, 1'b0, 1'b1));
        begin
            logic [37:0] j = '0;
            j[34:3] = 32'h11111111;
            strobe(1, j);
        end
        wait_idle();
        check_value("busy_error_set", {31'h0, bus.monitor_error}, 32'd1);
        check_mona("busy_mona", 8'h11);
        dbg_a(8'h10, 1'b1, 1'b0);
        check_value("error_cleared", {31'h0, bus.monitor_error}, 32'd0);
        dbg_a(8'h10, 1'b0, 1'b1);

        // Two strobes together: address load wins, read-next dropped.
        bus.jdo = jdo_a(8'h30, 1'b0, 1'b0);
        bus.take_action_ocimem_a = 1'b1;
        bus.take_no_action_ocimem_a = 1'b1;
        next_cycle();
        bus.take_action_ocimem_a = 1'b0;
        bus.take_no_action_ocimem_a = 1'b0;
        bus.jdo = '0;
        model_addr = 8'h30;
        @(negedge clk);
        check_value("multi_ready", {31'h0, bus.monitor_ready}, 32'd1);
        check_value("multi_error", {31'h0, bus.monitor_error}, 32'd1);
        check_mona("multi_mona", 8'h30);
        next_cycle();
        dbg_a(8'h30, 1'b1, 1'b0);

        // CPU write colliding with a debug write.
        dbg_a(8'h40, 1'b0, 1'b0);
        bus.jdo = '0;
        bus.jdo[34:3] = 32'h00000077;
        bus.take_action_ocimem_b = 1'b1;
        bus.cpu_write = 1'b1;
        bus.cpu_address = 8'h20;
        bus.cpu_writedata = 32'h5;
        model_mem[8'h40] = 32'h77;
        model_addr = 8'h41;
        dbg_q.push_back(model_mond);
        @(negedge clk);
        check_value("cpu_wait_strobe", {31'h0, bus.cpu_waitrequest}, 32'd1);
        next_cycle();
        bus.take_action_ocimem_b = 1'b0;
        bus.jdo = '0;
        @(negedge clk);
        check_value("cpu_wait_busy", {31'h0, bus.cpu_waitrequest}, 32'd1);
        next_cycle();
        @(negedge clk);
        check_value("cpu_accept", {31'h0, bus.cpu_waitrequest}, 32'd0);
        next_cycle();
        bus.cpu_write = 1'b0;
        model_mem[8'h20] = 32'h5;
        dbg_a(8'h20, 1'b0, 1'b1);

        // CPU read latency, then write-wins when both requested.
        cpu_do(1'b1, 1'b0, 8'h40, 32'h0);
        @(negedge clk);
        check_value("cpu_rv_m1", {31'h0, bus.cpu_readdatavalid}, 32'd0);
        @(negedge clk);
        check_value("cpu_rv_m2", {31'h0, bus.cpu_readdatavalid}, 32'd1);
        @(negedge clk);
        check_value("cpu_rv_m3", {31'h0, bus.cpu_readdatavalid}, 32'd0);
        next_cycle();
        cpu_do(1'b1, 1'b1, 8'h41, 32'h99);
        cpu_do(1'b1, 1'b0, 8'h41, 32'h0);
        repeat (4) next_cycle();

        // Reset while in RD_ADDR.
        strobe(0, jdo_a(8'h10, 1'b0, 1'b1));
        reset = 1'b1;
        #1;
        check_value("midrst_mondreg", bus.MonDReg, 32'h0);
        check_value("midrst_ready", {31'h0, bus.monitor_ready}, 32'd1);
        check_mona("midrst_mona", 8'h00);
        @(negedge clk);
        #1;
        reset = 1'b0;
        dbg_q.delete();
        cpu_q.delete();
        model_mond = 32'h0;
        model_addr = 8'h00;
        next_cycle();
        dbg_a(8'h10, 1'b0, 1'b1);
        dbg_n();
        dbg_a(8'h20, 1'b0, 1'b1);
        dbg_a(8'h00, 1'b0, 1'b1);

        repeat (3) next_cycle();
        check_value("dbg_sb_drained", dbg_q.size(), 32'd0);
        check_value("cpu_sb_drained", cpu_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
